// File: rtl/score_judge_accumulator.sv
// Game statistics accumulator: combo, scores and a restoring-divider accuracy/rank.
// Optional build macro SCORE_BAD_BREAK_EN makes a "bad" judgement break the combo.
module score_judge_accumulator #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         hit_valid,
  input  logic [1:0]   hit_grade,
  input  logic [1:0]   mod,
  input  logic [3:0]   difficulty,
  output logic [W-1:0] combo,
  output logic [W-1:0] base_score,
  output logic [W-1:0] bonus_score,
  output logic [W-1:0] acc,
  output logic [2:0]   level,
  output logic         stat_valid,
  output logic         busy
);

  localparam int IW = $clog2(W);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  function automatic logic [2:0] level_of(input logic [W-1:0] q, input logic clean,
                                          input logic empty);
    logic [W+15:0] qw;
    qw = {16'd0, q};
    if (empty) return 3'd0;
    if (clean && qw == (W+16)'(10000)) return 3'd6;
    if (qw >= (W+16)'(9500)) return 3'd5;
    if (qw >= (W+16)'(9000)) return 3'd4;
    if (qw >= (W+16)'(8000)) return 3'd3;
    if (qw >= (W+16)'(7000)) return 3'd2;
    return 3'd1;
  endfunction

  logic [1:0]    state;
  logic [IW-1:0] iter;
  logic          pend;
  logic          miss_seen;
  logic [W-1:0]  notes;
  logic [W-1:0]  raw_sum;

  logic          accept;
  logic          breaks;
  logic [W-1:0]  raw_pts;
  logic [W-1:0]  mod_pts;
  logic [W-1:0]  combo_new;
  logic [6:0]    cap;
  logic [10:0]   bonus_prod;
  logic [W-1:0]  bonus_inc;
  logic [W+6:0]  num_wide;
  logic [W+1:0]  den_wide;
  logic [W-1:0]  num_snap;
  logic [W-1:0]  den_snap;

  logic [W-1:0]  num_p0;
  logic [W-1:0]  den_p0;
  logic          clean_p0;
  logic          empty_p0;
  logic [W-1:0]  rem_p1;
  logic [W-1:0]  quo_p1;
  logic [W:0]    shifted;
  logic          fits;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quo_next;

  always_comb begin
    accept = hit_valid && en;
    case (hit_grade)
      2'd1:    raw_pts = W'(50);
      2'd2:    raw_pts = W'(100);
      2'd3:    raw_pts = W'(300);
      default: raw_pts = '0;
    endcase
    case (mod)
      2'd1:    mod_pts = raw_pts << 1;
      2'd2:    mod_pts = raw_pts >> 1;
      default: mod_pts = raw_pts;
    endcase
`ifdef SCORE_BAD_BREAK_EN
    breaks = (hit_grade == 2'd0) || (hit_grade == 2'd1);
`else
    breaks = (hit_grade == 2'd0);
`endif
    combo_new  = breaks ? '0 : sat_add(combo, W'(1));
    cap        = (combo_new > W'(64)) ? 7'd64 : combo_new[6:0];
    bonus_prod = 11'(difficulty) * 11'(cap);
    bonus_inc  = breaks ? '0 : W'(bonus_prod);

    // Snapshot operands, clamped so an overflowing product never wraps.
    num_wide = (W+7)'(raw_sum) * (W+7)'(100);
    den_wide = (W+2)'(notes) * (W+2)'(3);
    num_snap = (|num_wide[W+6:W]) ? {W{1'b1}} : num_wide[W-1:0];
    den_snap = (|den_wide[W+1:W]) ? {W{1'b1}} : den_wide[W-1:0];

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    shifted  = {rem_p1, quo_p1[W-1]};
    fits     = shifted >= {1'b0, den_p0};
    rem_next = fits ? W'(shifted - {1'b0, den_p0}) : shifted[W-1:0];
    quo_next = {quo_p1[W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      combo       <= '0;
      base_score  <= '0;
      bonus_score <= '0;
      acc         <= '0;
      level       <= 3'd0;
      notes       <= '0;
      raw_sum     <= '0;
      miss_seen   <= 1'b0;
      pend        <= 1'b0;
      state       <= S_IDLE;
      iter        <= '0;
    end else begin
      // A hit accepted on the start edge keeps the request alive for the next run.
      pend <= accept || (pend && state != S_IDLE);
      if (accept) begin
        notes       <= sat_add(notes, W'(1));
        raw_sum     <= sat_add(raw_sum, raw_pts);
        combo       <= combo_new;
        base_score  <= sat_add(base_score, mod_pts);
        bonus_score <= sat_add(bonus_score, bonus_inc);
        if (hit_grade == 2'd0) miss_seen <= 1'b1;
      end
      case (state)
        S_IDLE: if (pend) state <= S_LOAD;
        S_LOAD: begin
          iter  <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          iter <= iter + IW'(1);
          if (iter == IW'(W-1)) state <= S_DONE;
        end
        S_DONE: begin
          acc   <= empty_p0 ? '0 : quo_p1;
          level <= level_of(quo_p1, clean_p0, empty_p0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Divider datapath: snapshot (p0) then iterate remainder/quotient (p1).
  always_ff @(posedge clk) begin
    if (state == S_IDLE && pend) begin
      num_p0   <= num_snap;
      den_p0   <= den_snap;
      clean_p0 <= !miss_seen;
      empty_p0 <= (notes == '0);
    end
    if (state == S_LOAD) begin
      rem_p1 <= '0;
      quo_p1 <= num_p0;
    end else if (state == S_DIV) begin
      rem_p1 <= rem_next;
      quo_p1 <= quo_next;
    end
  end

  assign busy       = pend || (state != S_IDLE);
  assign stat_valid = !busy;

endmodule

// File: tb/tb_score_judge_accumulator.sv
// Scoreboard bench for score_judge_accumulator: directed hits, queued expectations, monitor checks.
module tb_score_judge_accumulator;
  logic        clk = 1'b0;
  logic        rst, en, clr, hit_valid;
  logic [1:0]  hit_grade, mod;
  logic [3:0]  difficulty;
  logic [31:0] combo, base_score, bonus_score, acc;
  logic [2:0]  level;
  logic        stat_valid, busy;
  logic [11:0] combo_s, base_s, bonus_s, acc_s;
  logic [2:0]  level_s;
  logic        stat_valid_s, busy_s;

  score_judge_accumulator #(.W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .hit_valid(hit_valid),
    .hit_grade(hit_grade), .mod(mod), .difficulty(difficulty),
    .combo(combo), .base_score(base_score), .bonus_score(bonus_score),
    .acc(acc), .level(level), .stat_valid(stat_valid), .busy(busy)
  );

  // Narrow instance so saturation is reachable in a short run.
  score_judge_accumulator #(.W(12)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .hit_valid(hit_valid),
    .hit_grade(hit_grade), .mod(mod), .difficulty(difficulty),
    .combo(combo_s), .base_score(base_s), .bonus_score(bonus_s),
    .acc(acc_s), .level(level_s), .stat_valid(stat_valid_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  typedef struct {int unsigned c; int unsigned b; int unsigned bo;} cnt_t;
  typedef struct {int unsigned a; int unsigned l;} res_t;
  cnt_t cnt_q[$];
  res_t res_q[$];
  cnt_t ce;
  res_t re;
  int   total = 0;
  int   bad = 0;
  logic mon_on = 1'b0;
  logic acc_d = 1'b0;
  logic sv_prev = 1'b1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) acc_d <= hit_valid && en && !rst && !clr;

  always @(negedge clk) begin
    if (mon_on) begin
      if (acc_d) begin
        if (cnt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cnt_unexpected: got counter update, want none");
        end else begin
          ce = cnt_q.pop_front();
          chk("combo", combo, ce.c);
          chk("base_score", base_score, ce.b);
          chk("bonus_score", bonus_score, ce.bo);
        end
      end
      if (stat_valid && !sv_prev) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL res_unexpected: got acc=%0d level=%0d, want no result", acc, level);
        end else begin
          re = res_q.pop_front();
          chk("acc", acc, re.a);
          chk("level", level, re.l);
        end
      end
    end
    sv_prev = stat_valid;
  end

  task automatic pushc(input int unsigned c, input int unsigned b, input int unsigned bo);
    cnt_q.push_back('{c, b, bo});
  endtask

  task automatic pushr(input int unsigned a, input int unsigned l);
    res_q.push_back('{a, l});
  endtask

  task automatic hit(input logic [1:0] g);
    hit_grade = g;
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    int n;
    rst = 1'b1; clr = 1'b0; en = 1'b1; hit_valid = 1'b1;
    hit_grade = 2'd3; mod = 2'd0; difficulty = 4'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0; hit_valid = 1'b0;
    chk("rst_combo", combo, 0);
    chk("rst_base", base_score, 0);
    chk("rst_bonus", bonus_score, 0);
    chk("rst_acc", acc, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", stat_valid, 1);
    chk("rst_busy", busy, 0);
    mon_on = 1'b1;

    // Four perfects back to back.
    pushc(1, 300, 2);  hit(2'd3);
    pushc(2, 600, 6);  hit(2'd3);
    pushc(3, 900, 12); hit(2'd3);
    pushr(10000, 6);
    pushc(4, 1200, 20); hit(2'd3);
    wait_idle("perfect4");

    pushr(8000, 3);
    pushc(0, 1200, 20); hit(2'd0);
    wait_idle("miss");

    mod = 2'd1;
    pushr(7222, 2);
    pushc(1, 1400, 22); hit(2'd2);
    wait_idle("good_hard");

    // Second hit lands on divider iteration 10.
    mod = 2'd0;
    pushc(2, 1700, 26); hit(2'd3);
    repeat (11) @(negedge clk);
    pushr(7083, 2);
    pushc(3, 1800, 32); hit(2'd2);
    n = 0;
    while (acc == 32'd7222 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stale_acc", acc, 7619);
    chk("stale_busy", busy, 1);
    chk("stale_valid", stat_valid, 0);
    wait_idle("rerun");

    // clr collides with a hit during a division.
    pushc(4, 2100, 40); hit(2'd3);
    repeat (5) @(negedge clk);
    pushr(0, 0);
    clr = 1'b1; hit_valid = 1'b1; hit_grade = 2'd3;
    @(negedge clk);
    clr = 1'b0; hit_valid = 1'b0;
    chk("clr_combo", combo, 0);
    chk("clr_base", base_score, 0);
    chk("clr_bonus", bonus_score, 0);
    chk("clr_acc", acc, 0);
    chk("clr_level", level, 0);
    chk("clr_busy", busy, 0);
    repeat (50) @(negedge clk);
    chk("clr_late_acc", acc, 0);
    chk("clr_late_level", level, 0);
    chk("clr_late_valid", stat_valid, 1);

    // Long combo past the 64 cap at difficulty 15.
    difficulty = 4'd15;
    b = 0;
    for (int i = 1; i <= 66; i++) begin
      b += 15 * ((i < 64) ? i : 64);
      if (i == 66) pushr(10000, 6);
      pushc(i, 300 * i, b);
      hit(2'd3);
    end
    wait_idle("long_combo");
    chk("bonus_total", bonus_score, 33120);
    chk("sat_combo_s", combo_s, 66);
    chk("sat_base_s", base_s, 4095);
    chk("sat_bonus_s", bonus_s, 4095);

    en = 1'b0;
    hit_valid = 1'b1; hit_grade = 2'd3;
    @(negedge clk);
    hit_valid = 1'b0;
    @(negedge clk);
    chk("en_low_combo", combo, 66);
    chk("en_low_busy", busy, 0);
    en = 1'b1;

    chk("cnt_q_left", cnt_q.size(), 0);
    chk("res_q_left", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_judge_accumulator.md
Name: score_judge_accumulator

Overview:
- Upstream of the scoreboard display block.
- Consumes per-note judgement pulses from the rhythm-judge stage and accumulates the game statistics that the scoreboard multiplexes onto the tubes: combo, base_score, bonus_score, acc and level.
- Accuracy needs a division, which is done by an iterative restoring divider. acc and level therefore trail the counters by a fixed latency and carry a validity flag.

Parameters:
- W, 32, width of every statistic counter and of the divider datapath (matches MAX_NUM).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  game active; hits are ignored when low.
- clr  in  1  synchronous clear of all statistics at the start of a song; same effect as rst.
- hit_valid  in  1  one-cycle judgement pulse.
- hit_grade  in  2  0=miss, 1=bad, 2=good, 3=perfect.
- mod  in  2  0=normal x1, 1=hard x2, 2=easy x1/2, 3=normal x1.
- difficulty  in  4  song difficulty, 0..15.
- combo  out  W  current combo.
- base_score  out  W  modded base score.
- bonus_score  out  W  combo bonus.
- acc  out  W  accuracy in hundredths of a percent, 0..10000.
- level  out  3  rank: 0=none, 1=D, 2=C, 3=B, 4=A, 5=S, 6=SS.
- stat_valid  out  1  acc and level reflect every accepted hit.
- busy  out  1  divider running or a division pending.

Behaviour:
- Reset / clr:
  - All outputs and internal counters go to 0, stat_valid=1, busy=0.
  - The divider is aborted, and any pending request is dropped.
  - clr has priority over a coinciding hit_valid; that hit is lost.
- Hit acceptance: a hit is accepted when hit_valid=1 and en=1 at a clk edge. The registered outputs update on the next edge (1-cycle latency).
- Raw points: miss=0, bad=50, good=100, perfect=300.
- Internal counters: notes increments on every accepted hit; raw_sum adds the unmodded raw points.
- Combo: incremented on bad/good/perfect; set to 0 on miss.
- base_score: adds raw points scaled by mod: x2 for mod=1, >>1 for mod=2, x1 otherwise.
- bonus_score: on a non-miss hit, adds difficulty * min(new_combo, 64). A miss adds nothing.
- Saturation: every counter saturates at all-ones and never wraps.
- Division request: raised on every accepted hit.
- Division start:
  - Begins when the divider is idle and a request is pending.
  - The cycle it starts, it snapshots numerator = raw_sum*100 (saturated to W bits) and denominator = notes*3.
- Divider FSM:
  - IDLE -> LOAD -> DIV (exactly W iterations, one quotient bit per cycle) -> DONE -> IDLE.
  - DONE writes acc and level together.
- Latency: with no other hits, acc/level are updated W+3 cycles after hit_valid.
- Hit while dividing:
  - The counters update normally and the request flag is set.
  - The current division completes and publishes its (stale) result.
  - The next division then starts from fresh snapshots; results are never discarded mid-run.
- Flags: stat_valid=0 and busy=1 from the cycle after an accepted hit until a DONE with no request pending.
- Level mapping from acc:
  - notes==0 -> acc=0, level=0.
  - acc==10000 and no miss since clear -> 6.
  - Otherwise >=9500 -> 5, >=9000 -> 4, >=8000 -> 3, >=7000 -> 2, else 1.
- en low: new hits are ignored, but a running or pending division still completes.

Optional Feature:
- Macro SCORE_BAD_BREAK_EN.
- When defined, grade bad also resets combo to 0 and adds no bonus; it still scores 50 raw points.
- When undefined, bad continues the combo as described above.

Test Plan:
- rst high for 2 cycles with hit_valid=1 -> all outputs 0, stat_valid=1, busy=0.
- difficulty=2, mod=0, 4 perfects on consecutive cycles -> combo=4, base_score=1200, bonus_score=20; after busy falls, acc=10000, level=6.
- Continue with 1 miss -> combo=0, base_score=1200, bonus unchanged at 20, acc=1200*100/15=8000, level=3.
- Then mod=1, 1 good -> combo=1, base_score=1400, bonus_score=22, acc=130000/18=7222, level=2.
- Hit arriving at iteration 10 of a running division:
  - The first result is published, busy stays 1, and a second division runs.
  - The final acc matches all hits, and stat_valid rises only after the second DONE.
- clr asserted in the same cycle as a hit mid-division -> all statistics 0 next cycle, no later acc write; bonus with combo>64 at difficulty=15 adds 960 per hit; base_score driven near all-ones saturates.
